// File: rtl/sync_fifo_flags.sv
// rtl/sync_fifo_flags.sv - single-clock FIFO with programmable thresholds, fill level, watermark and sticky errors
// Supports a standard registered read or first-word-fall-through presentation of the head entry.
module sync_fifo_flags #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4,
    parameter int FWFT       = 0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  wr_en,
    output logic                  wr_full,
    output logic                  wr_almost_full,
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_valid,
    output logic                  rd_empty,
    output logic                  rd_almost_empty,
    input  logic [ADDR_WIDTH:0]   af_thresh,
    input  logic [ADDR_WIDTH:0]   ae_thresh,
    output logic [ADDR_WIDTH:0]   level,
    output logic [ADDR_WIDTH:0]   max_level,
    output logic                  overflow,
    output logic                  underflow,
    input  logic                  clr_err
);

    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] FULL_LEVEL = (ADDR_WIDTH+1)'(DEPTH);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_WIDTH:0]   level_q, level_d;
    logic [ADDR_WIDTH:0]   max_level_q, max_level_d;
    logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
    logic                  rd_valid_q, rd_valid_d;
    logic                  overflow_q, overflow_d;
    logic                  underflow_q, underflow_d;
    logic                  full, empty, wr_acc, rd_acc;

    // Full/empty come from the occupancy count so pointer wrap needs no extra bit.
    assign full  = (level_q == FULL_LEVEL);
    assign empty = (level_q == '0);

    always_comb begin
        wr_acc      = wr_en && !full;
        rd_acc      = rd_en && !empty;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        level_d     = level_q;
        rd_data_d   = rd_data_q;
        rd_valid_d  = rd_acc;
        overflow_d  = overflow_q;
        underflow_d = underflow_q;

        if (wr_acc) begin
            wr_ptr_d = wr_ptr_q + ADDR_WIDTH'(1);
        end
        if (rd_acc) begin
            rd_ptr_d  = rd_ptr_q + ADDR_WIDTH'(1);
            rd_data_d = mem_q[rd_ptr_q];
        end

        case ({wr_acc, rd_acc})
            2'b10:   level_d = level_q + (ADDR_WIDTH+1)'(1);
            2'b01:   level_d = level_q - (ADDR_WIDTH+1)'(1);
            default: level_d = level_q;
        endcase

        // A new error event takes priority over a coincident clear.
        if (clr_err) begin
            overflow_d  = 1'b0;
            underflow_d = 1'b0;
        end
        if (wr_en && full) begin
            overflow_d = 1'b1;
        end
        if (rd_en && empty) begin
            underflow_d = 1'b1;
        end

        if (clr_err) begin
            max_level_d = level_d;
        end else if (level_d > max_level_q) begin
            max_level_d = level_d;
        end else begin
            max_level_d = max_level_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            level_q     <= '0;
            max_level_q <= '0;
            rd_data_q   <= '0;
            rd_valid_q  <= 1'b0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            level_q     <= level_d;
            max_level_q <= max_level_d;
            rd_data_q   <= rd_data_d;
            rd_valid_q  <= rd_valid_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    // Storage is not reset; its contents are don't-care after reset.
    always_ff @(posedge clk) begin
        if (wr_acc) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

    assign wr_full         = full;
    assign rd_empty        = empty;
    assign wr_almost_full  = (level_q >= af_thresh);
    assign rd_almost_empty = (level_q <= ae_thresh);
    assign level           = level_q;
    assign max_level       = max_level_q;
    assign overflow        = overflow_q;
    assign underflow       = underflow_q;
    assign rd_data         = (FWFT != 0) ? (empty ? '0 : mem_q[rd_ptr_q]) : rd_data_q;
    assign rd_valid        = (FWFT != 0) ? !empty : rd_valid_q;

endmodule

// File: tb/tb_sync_fifo_flags.sv
// tb/tb_sync_fifo_flags.sv - directed self-checking bench for sync_fifo_flags in standard and FWFT modes
module tb_sync_fifo_flags;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] wr_data;
    logic       wr_en, rd_en, clr_err;
    logic [4:0] af_thresh, ae_thresh;

    logic       s_full, s_afull, s_valid, s_empty, s_aempty, s_ovf, s_unf;
    logic [7:0] s_data;
    logic [4:0] s_level, s_max;
    logic       f_full, f_afull, f_valid, f_empty, f_aempty, f_ovf, f_unf;
    logic [7:0] f_data;
    logic [4:0] f_level, f_max;

    int checks = 0;
    int errors = 0;
    int w, r;

    always #5 clk = ~clk;

    sync_fifo_flags #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .FWFT(0)) dut_std (
        .clk(clk), .rst_n(rst_n), .wr_data(wr_data), .wr_en(wr_en),
        .wr_full(s_full), .wr_almost_full(s_afull), .rd_en(rd_en),
        .rd_data(s_data), .rd_valid(s_valid), .rd_empty(s_empty),
        .rd_almost_empty(s_aempty), .af_thresh(af_thresh), .ae_thresh(ae_thresh),
        .level(s_level), .max_level(s_max), .overflow(s_ovf), .underflow(s_unf),
        .clr_err(clr_err)
    );

    sync_fifo_flags #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .FWFT(1)) dut_fwft (
        .clk(clk), .rst_n(rst_n), .wr_data(wr_data), .wr_en(wr_en),
        .wr_full(f_full), .wr_almost_full(f_afull), .rd_en(rd_en),
        .rd_data(f_data), .rd_valid(f_valid), .rd_empty(f_empty),
        .rd_almost_empty(f_aempty), .af_thresh(af_thresh), .ae_thresh(ae_thresh),
        .level(f_level), .max_level(f_max), .overflow(f_ovf), .underflow(f_unf),
        .clr_err(clr_err)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0; wr_data = '0; wr_en = 1'b0; rd_en = 1'b0; clr_err = 1'b0;
        af_thresh = 5'd0; ae_thresh = 5'd3;
        #12;
        check("rst_level", s_level, 0);
        check("rst_max", s_max, 0);
        check("rst_empty", s_empty, 1);
        check("rst_full", s_full, 0);
        check("rst_aempty", s_aempty, 1);
        check("rst_afull_thr0", s_afull, 1);
        check("rst_valid", s_valid, 0);
        check("rst_data", s_data, 0);
        check("rst_ovf", s_ovf, 0);
        check("rst_unf", s_unf, 0);
        check("rst_fwft_valid", f_valid, 0);
        af_thresh = 5'd12;
        #1;
        check("rst_afull_thr12", s_afull, 0);
        rst_n = 1'b1;
        tick();

        // Fill with 0x00..0x0F, tracking threshold flags at every level.
        for (int i = 0; i < 16; i++) begin
            wr_en = 1'b1; wr_data = 8'(i);
            tick();
            check("fill_level", s_level, i + 1);
            check("fill_afull", s_afull, (i + 1 >= 12) ? 1 : 0);
            check("fill_aempty", s_aempty, (i + 1 <= 3) ? 1 : 0);
            if (i == 0) begin
                check("fwft_first_valid", f_valid, 1);
                check("fwft_first_data", f_data, 8'h00);
            end
        end
        check("fill_full", s_full, 1);
        check("fill_max", s_max, 16);
        af_thresh = 5'd17;
        #1;
        check("afull_thr_above_depth", s_afull, 0);
        af_thresh = 5'd12;
        wr_data = 8'hFF;
        tick();
        wr_en = 1'b0;
        check("ovf_set", s_ovf, 1);
        check("ovf_level", s_level, 16);
        check("ovf_unf_clear", s_unf, 0);

        // Drain in order with back-to-back reads.
        for (int i = 0; i < 16; i++) begin
            check("fwft_head", f_data, 8'(i));
            rd_en = 1'b1;
            tick();
            check("drain_valid", s_valid, 1);
            check("drain_data", s_data, 8'(i));
            check("drain_level", s_level, 15 - i);
        end
        check("drain_empty", s_empty, 1);
        tick();
        rd_en = 1'b0;
        check("unf_set", s_unf, 1);
        check("unf_valid", s_valid, 0);
        check("unf_level", s_level, 0);
        tick();
        check("valid_pulse_end", s_valid, 0);
        check("data_hold", s_data, 8'h0F);
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
        check("clr_ovf", s_ovf, 0);
        check("clr_unf", s_unf, 0);
        check("clr_max", s_max, 0);

        // Bring level to 8, then stream simultaneous read+write across pointer wrap.
        w = 0; r = 0;
        for (int i = 0; i < 8; i++) begin
            wr_en = 1'b1; wr_data = 8'(w); w++;
            tick();
        end
        check("mid_level", s_level, 8);
        for (int i = 0; i < 100; i++) begin
            wr_en = 1'b1; rd_en = 1'b1; wr_data = 8'(w); w++;
            tick();
            check("stream_level", s_level, 8);
            check("stream_valid", s_valid, 1);
            check("stream_data", s_data, 8'(r)); r++;
        end
        wr_en = 1'b0;
        check("stream_ovf", s_ovf, 0);
        check("stream_unf", s_unf, 0);
        check("stream_max", s_max, 8);
        for (int i = 0; i < 3; i++) begin
            rd_en = 1'b1;
            tick();
            check("tail_data", s_data, 8'(r)); r++;
        end
        check("pre_rst_level", s_level, 5);
        check("pre_rst_valid", s_valid, 1);

        // Asynchronous reset between clock edges.
        rst_n = 1'b0; rd_en = 1'b0;
        #1;
        check("arst_level", s_level, 0);
        check("arst_valid", s_valid, 0);
        check("arst_empty", s_empty, 1);
        check("arst_max", s_max, 0);
        check("arst_data", s_data, 0);
        check("arst_aempty", s_aempty, 1);
        check("arst_fwft_valid", f_valid, 0);
        rst_n = 1'b1;
        tick();

        // FWFT single-word latency and pop.
        wr_en = 1'b1; wr_data = 8'hA5;
        tick();
        wr_en = 1'b0;
        check("fwft_valid", f_valid, 1);
        check("fwft_data", f_data, 8'hA5);
        check("std_no_valid", s_valid, 0);
        tick();
        check("fwft_hold_valid", f_valid, 1);
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        check("fwft_pop_empty", f_empty, 1);
        check("fwft_pop_valid", f_valid, 0);
        check("std_late_valid", s_valid, 1);
        check("std_late_data", s_data, 8'hA5);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
